// File: rtl/cnn_pkg.sv
// Shared CNN pipeline defaults and the bank-state type used by the flatten buffer.
package cnn_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int FC_N       = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;
endpackage

// File: rtl/fc_flatten_buffer_if.sv
// Feature-stream input and flattened-vector output handshakes of the flatten buffer.
interface fc_flatten_buffer_if
  import cnn_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int N     = FC_N
);
  localparam int CW = $clog2(N + 1);

  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic [N*WIDTH-1:0]      m_vec;
  logic [CW-1:0]           m_count;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_vec, m_count
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_vec, m_count
  );
endinterface

// File: rtl/fc_flatten_buffer_bank.sv
// One ping-pong bank: N-element register array, real-element count and bank state.
//   state   | meaning
//   EMPTY   | cleared, no element written yet
//   FILLING | at least one element written, vector still open
//   FULL    | vector closed, waiting for the FC stage to take it
module fc_flatten_bank
  import cnn_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int N     = FC_N,
  localparam int IW   = $clog2(N),
  localparam int CW   = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [IW-1:0]      idx,
  input  logic [WIDTH-1:0]   din,
  input  logic               close,
  input  logic               rel,
  output logic [N*WIDTH-1:0] vec,
  output logic [CW-1:0]      count,
  output bank_state_t        state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec   <= '0;
      count <= '0;
      state <= EMPTY;
    end else if (rel) begin
      // Clearing on release is what zero-pads vectors closed early by s_last.
      vec   <= '0;
      count <= '0;
      state <= EMPTY;
    end else if (we) begin
      vec[idx*WIDTH +: WIDTH] <= din;
      if (close) begin
        count <= CW'(idx) + CW'(1);
        state <= FULL;
      end else begin
        state <= FILLING;
      end
    end
  end

endmodule

// File: rtl/fc_flatten_buffer.sv
// Serial-to-parallel ping-pong buffer packing N signed features into one FC input vector.
module fc_flatten_buffer
  import cnn_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int N     = FC_N,
  localparam int IW   = $clog2(N),
  localparam int CW   = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  fc_flatten_buffer_if.slave  bus
);

  logic          wr_sel;
  logic          rd_sel;
  logic [IW-1:0] wr_idx;

  logic               xfer_in;
  logic               xfer_out;
  logic               close;
  bank_state_t        st0, st1;
  logic [N*WIDTH-1:0] vec0, vec1;
  logic [CW-1:0]      cnt0, cnt1;

  // Both handshake outputs depend only on bank state and the select registers.
  assign bus.s_ready = ((wr_sel ? st1 : st0) != FULL);
  assign bus.m_valid = ((rd_sel ? st1 : st0) == FULL);
  assign bus.m_vec   = rd_sel ? vec1 : vec0;
  assign bus.m_count = rd_sel ? cnt1 : cnt0;

  assign xfer_in  = bus.s_valid && bus.s_ready;
  assign xfer_out = bus.m_valid && bus.m_ready;
  assign close    = xfer_in && ((wr_idx == IW'(N - 1)) || bus.s_last);

  fc_flatten_bank #(.WIDTH(WIDTH), .N(N)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (xfer_in && !wr_sel),
    .idx   (wr_idx),
    .din   (bus.s_data),
    .close (close),
    .rel   (xfer_out && !rd_sel),
    .vec   (vec0),
    .count (cnt0),
    .state (st0)
  );

  fc_flatten_bank #(.WIDTH(WIDTH), .N(N)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (xfer_in && wr_sel),
    .idx   (wr_idx),
    .din   (bus.s_data),
    .close (close),
    .rel   (xfer_out && rd_sel),
    .vec   (vec1),
    .count (cnt1),
    .state (st1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_idx <= '0;
    end else begin
      if (close) begin
        wr_idx <= '0;
        wr_sel <= ~wr_sel;
      end else if (xfer_in) begin
        wr_idx <= wr_idx + IW'(1);
      end
      if (xfer_out)
        rd_sel <= ~rd_sel;
    end
  end

endmodule

// File: tb/tb_fc_flatten_buffer.sv
// Scoreboard bench for fc_flatten_buffer: a feature-level model predicts each vector.
module tb_fc_flatten_buffer;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc_flatten_buffer_if #(.WIDTH(W), .N(N)) bus ();

  fc_flatten_buffer #(.WIDTH(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int acc_cnt = 0;

  logic [N*W+CW-1:0] sb_q[$];
  logic [N*W-1:0]    mdl_vec = '0;
  int                mdl_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_vec = '0;
    mdl_idx = 0;
    sb_q.delete();
  endtask

  // Holds the feature until accepted; valid is left high so calls chain back-to-back.
  task automatic send(input logic [W-1:0] d, input logic l);
    bit ok = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    acc_cnt++;
    mdl_vec[mdl_idx*W +: W] = d;
    if (mdl_idx == N - 1 || l) begin
      sb_q.push_back({mdl_vec, CW'(mdl_idx + 1)});
      mdl_vec = '0;
      mdl_idx = 0;
    end else begin
      mdl_idx++;
    end
  endtask

  task automatic idle(input int cycles);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_vec", 64'(bus.m_vec), 64'hDEAD);
      end else begin
        logic [N*W+CW-1:0] e;
        e = sb_q.pop_front();
        chk("m_vec", 64'(bus.m_vec), 64'(e[N*W+CW-1:CW]));
        chk("m_count", 64'(bus.m_count), 64'(e[CW-1:0]));
      end
    end
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_m_vec", 64'(bus.m_vec), 64'd0);
    chk("rst_m_count", 64'(bus.m_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic fill
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(W'(i), 1'b0);
    bus.s_valid = 1'b0;
    chk("lat_m_valid", 64'(bus.m_valid), 64'd1);
    chk("basic_vec", 64'(bus.m_vec), 64'h04030201);
    @(posedge clk); #1;
    chk("basic_drop", 64'(bus.m_valid), 64'd0);
    drain();

    // Signed values, padding, no stale data
    send(8'hFF, 1'b0);
    send(8'h80, 1'b1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("pad_vec", 64'(bus.m_vec), 64'h000080FF);
    chk("pad_count", 64'(bus.m_count), 64'd2);
    idle(1);
    for (int i = 5; i <= 8; i++) send(W'(i), 1'b0);
    bus.s_valid = 1'b0;
    chk("stale_vec", 64'(bus.m_vec), 64'h08070605);
    idle(1);
    drain();

    // Backpressure
    bus.m_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(W'(i), 1'b0);
        bus.s_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 200; i++) begin
          @(posedge clk); #2;
          if (acc_cnt >= 8) break;
        end
        chk("bp_acc", 64'(acc_cnt), 64'd8);
        chk("bp_s_ready", 64'(bus.s_ready), 64'd0);
        chk("bp_bank0", 64'(bus.m_vec), 64'h04030201);
        repeat (2) @(posedge clk);
        #2;
        chk("bp_hold_ready", 64'(bus.s_ready), 64'd0);
        chk("bp_hold_vec", 64'(bus.m_vec), 64'h04030201);
        bus.m_ready = 1'b1;
        @(posedge clk); #2;
        bus.m_ready = 1'b0;
        chk("bp_release_ready", 64'(bus.s_ready), 64'd1);
        chk("bp_bank1", 64'(bus.m_vec), 64'h08070605);
        repeat (3) @(posedge clk);
        #2;
        bus.m_ready = 1'b1;
      end
    join
    drain();

    // Simultaneous release of bank 0 and completion of bank 1
    bus.m_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(W'(8'h11 + i), 1'b0);
    bus.m_ready = 1'b1;
    send(8'h18, 1'b0);
    bus.s_valid = 1'b0;
    chk("sim_m_valid", 64'(bus.m_valid), 64'd1);
    chk("sim_vec", 64'(bus.m_vec), 64'h18171615);
    chk("sim_count", 64'(bus.m_count), 64'd4);
    drain();

    // Reset mid-fill
    for (int i = 0; i < 3; i++) send(W'(8'hA0 + i), 1'b0);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("mid_rst_s_ready", 64'(bus.s_ready), 64'd1);
    chk("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("mid_rst_m_vec", 64'(bus.m_vec), 64'd0);
    chk("mid_rst_m_count", 64'(bus.m_count), 64'd0);
    mdl_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    for (int i = 0; i < 4; i++) send(W'(8'hC0 + i), 1'b0);
    bus.s_valid = 1'b0;
    chk("post_rst_vec", 64'(bus.m_vec), 64'hC3C2C1C0);
    drain();

    // Stalled input with random gaps
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 4; i++) begin
        send(W'($urandom_range(0, 255)), 1'b0);
        idle($urandom_range(0, 3));
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_flatten_buffer.md
# fc_flatten_buffer

Serial-to-parallel ping-pong buffer that sits directly upstream of the fully connected stage. It accepts one signed WIDTH-bit feature per cycle from the pooling/conv stream through a valid/ready handshake. It packs N features into the flattened N*WIDTH vector the FC stage consumes, and presents each completed vector through a second valid/ready handshake. Two banks let ingest continue while a completed vector waits for the FC stage.

## Interface
- WIDTH, 8, feature bit width (signed two's complement)
- N, 4, features per output vector (N >= 2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  input feature valid
- s_ready  out  1  buffer can accept a feature this cycle
- s_data  in  WIDTH  signed input feature
- s_last  in  1  final feature of a group; closes the vector early
- m_valid  out  1  completed vector available
- m_ready  in  1  FC stage takes the vector this cycle
- m_vec  out  N*WIDTH  flattened vector; element i at bits [i*WIDTH +: WIDTH]
- m_count  out  $clog2(N+1)  number of real (non-padded) elements in m_vec, 1..N

## Operation
- Each bank has three states: EMPTY, FILLING, and FULL. Both banks start EMPTY. wr_sel names the bank being written and rd_sel names the bank being read. Both reset to 0 and toggle independently.
- Input transfer occurs when s_valid && s_ready. s_ready = (state[wr_sel] != FULL) and is driven from registers only, with no combinational path from s_valid or m_ready.
- On each transfer, s_data is written to element wr_idx of bank wr_sel, and the bank goes to FILLING.
  - If wr_idx == N-1 or s_last: the bank goes FULL, its count is set to wr_idx+1, wr_idx returns to 0, and wr_sel toggles.
  - Otherwise wr_idx increments.
- Elements that are never written stay zero, because banks are cleared on release. A vector closed by s_last is therefore zero-padded. This is safe for the FC dot product.
- m_valid = (state[rd_sel] == FULL). m_vec and m_count are the contents of bank rd_sel and are stable while m_valid && !m_ready.
- Output transfer occurs when m_valid && m_ready. Bank rd_sel is cleared to all zeros, its count is cleared, it goes EMPTY, and rd_sel toggles.
- Simultaneous completion of bank A and release of bank B in the same cycle: both take effect. The same bank can never be written and released in one cycle, because the write bank is never FULL.
- s_valid while !s_ready: no state change. The upstream stage holds s_data.
- s_last asserted without a transfer is ignored.

## Timing
- Reset values: s_ready=1, m_valid=0, m_vec=0, m_count=0. Internally wr_idx=0, wr_sel=0, rd_sel=0, and all bank contents are 0.
- Reset mid-operation discards any partial or full vectors. No output is produced for them.
- Latency: if the last element of a vector is accepted in cycle t, then m_valid=1 in cycle t+1.
- Throughput: one feature per cycle is sustained as long as the FC stage takes each vector within N cycles of m_valid rising.
- Backpressure: with both banks FULL, s_ready=0. After an output transfer in cycle t, s_ready=1 in cycle t+1.
- Ordering: vectors leave in completion order; the two banks alternate strictly.

## Structure
- Shared package cnn_pkg holds:
  - DATA_WIDTH=8 and FC_N=4, the defaults shared with the FC stage.
  - The bank-state enum: EMPTY, FILLING, FULL.
- Sub-module fc_flatten_bank is instantiated twice. It contains one N*WIDTH register array, its count, and its state. Its ports are write-enable+index+data, close, and release/clear.
- The top level holds wr_sel, rd_sel, wr_idx, the handshake logic, and the output mux.

## Test plan
- **Basic fill:** after reset, stream 1,2,3,4 on consecutive cycles with m_ready=1.
  - m_valid=1 one cycle after 4 is accepted.
  - m_vec=0x04030201, m_count=4, and m_valid drops the next cycle.
- **Signed values and padding:** stream -1, -128 (0xFF, 0x80) with s_last on -128.
  - Required: m_vec=0x000080FF and m_count=2.
  - The next vector 5,6,7,8 must not carry stale data (m_vec=0x08070605).
- **Backpressure with m_ready=0:** stream 12 features continuously.
  - s_ready falls after 8 accepted; banks hold 0x04030201 and 0x08070605.
  - Raise m_ready for one cycle: the first vector exits, and s_ready=1 on the next cycle.
  - Features 9..12 then fill the freed bank, and vectors exit in order.
- **Simultaneous events:** time bank 0 release (m_ready=1) in the same cycle bank 1 accepts its 4th element.
  - Bank 1 appears on m_vec the next cycle with m_valid=1 and no lost or duplicated vector.
- **Reset mid-fill:** accept 3 features, then pulse rst.
  - All outputs return to reset values.
  - The next 4 features form a vector with m_count=4 containing only the post-reset data.
- **Stalled input:** hold s_valid=0 for random gaps mid-vector.
  - wr_idx must not advance; m_vec equals the accepted features in order.
